// File: rtl/ro_meas_scheduler.sv
// Ring-oscillator measurement sequencer: decodes UART command bytes and runs the
// settle / clear / gate / hold sequence, handing each count out over valid/ready.
module ro_meas_scheduler #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    input  logic [7:0]       cmd_data_i,
    output logic [1:0]       osc_en_o,
    output logic             osc_sel_o,
    output logic             cnt_clear_o,
    output logic             cnt_en_o,
    input  logic [CNT_W-1:0] cnt_value_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_data_o,
    output logic             res_src_o,
    output logic             res_sat_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CLEAR,
        ST_GATE,
        ST_HOLD,
        ST_REPORT
    } state_e;

    typedef enum logic [1:0] {
        MODE_INV,
        MODE_NAND,
        MODE_ALT
    } mode_e;

    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] HOLD_M1   = 16'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    mode_e            act_mode_q, act_mode_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       act_exp_q, act_exp_d;
    logic             cont_q, cont_d;
    logic             src_q, src_d;
    logic [15:0]      cyc_q, cyc_d;
    logic [CNT_W-1:0] res_data_q, res_data_d;
    logic             res_src_q, res_src_d;
    logic             res_sat_q, res_sat_d;

    logic             start_cmd;
    logic             run_cmd;
    logic             stop_cmd;
    logic [15:0]      gate_m1;

    // Gate length 2^(N+8) cycles, loaded as a down-count terminal value.
    assign gate_m1 = (16'h0100 << act_exp_q) - 16'd1;

    assign start_cmd = cmd_valid_i && (cmd_data_i == 8'h01);
    assign run_cmd   = cmd_valid_i && (cmd_data_i == 8'h02);
    assign stop_cmd  = cmd_valid_i && (cmd_data_i == 8'h03);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_INV;
            act_mode_q <= MODE_INV;
            exp_q      <= 3'd2;
            act_exp_q  <= 3'd2;
            cont_q     <= 1'b0;
            src_q      <= 1'b0;
            cyc_q      <= 16'd0;
            res_data_q <= '0;
            res_src_q  <= 1'b0;
            res_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            act_mode_q <= act_mode_d;
            exp_q      <= exp_d;
            act_exp_q  <= act_exp_d;
            cont_q     <= cont_d;
            src_q      <= src_d;
            cyc_q      <= cyc_d;
            res_data_q <= res_data_d;
            res_src_q  <= res_src_d;
            res_sat_q  <= res_sat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        act_mode_d = act_mode_q;
        exp_d      = exp_q;
        act_exp_d  = act_exp_q;
        cont_d     = cont_q;
        src_d      = src_q;
        cyc_d      = cyc_q;
        res_data_d = res_data_q;
        res_src_d  = res_src_q;
        res_sat_d  = res_sat_q;

        if (cmd_valid_i) begin
            case (cmd_data_i)
                8'h10:   mode_d = MODE_INV;
                8'h11:   mode_d = MODE_NAND;
                8'h12:   mode_d = MODE_ALT;
                default: begin
                    if (cmd_data_i[7:3] == 5'b00100) begin
                        exp_d = cmd_data_i[2:0];
                    end
                end
            endcase
        end

        if (stop_cmd) begin
            cont_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_cmd || run_cmd) begin
                    state_d    = ST_SETTLE;
                    cyc_d      = SETTLE_M1;
                    act_mode_d = mode_q;
                    act_exp_d  = exp_q;
                    src_d      = (mode_q == MODE_NAND);
                    cont_d     = run_cmd;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == 16'd0) begin
                    state_d = ST_CLEAR;
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_GATE;
                cyc_d   = gate_m1;
            end
            ST_GATE: begin
                if (cyc_q == 16'd0) begin
                    state_d = ST_HOLD;
                    cyc_d   = HOLD_M1;
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            ST_HOLD: begin
                if (cyc_q == 16'd0) begin
                    state_d    = ST_REPORT;
                    res_data_d = cnt_value_i;
                    res_src_d  = src_q;
                    res_sat_d  = &cnt_value_i;
                end else begin
                    cyc_d = cyc_q - 16'd1;
                end
            end
            ST_REPORT: begin
                if (res_ready_i) begin
                    // The NAND half of an ALT pair runs even if STOP arrives now.
                    if ((act_mode_q == MODE_ALT) && !src_q) begin
                        state_d = ST_SETTLE;
                        cyc_d   = SETTLE_M1;
                        src_d   = 1'b1;
                    end else if (cont_q && !stop_cmd) begin
                        state_d    = ST_SETTLE;
                        cyc_d      = SETTLE_M1;
                        act_mode_d = mode_q;
                        act_exp_d  = exp_q;
                        src_d      = (mode_q == MODE_NAND);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Source only changes on SETTLE entry, so the enable is one-hot outside IDLE.
    assign busy_o      = (state_q != ST_IDLE);
    assign osc_en_o    = busy_o ? (src_q ? 2'b10 : 2'b01) : 2'b00;
    assign osc_sel_o   = busy_o & src_q;
    assign cnt_clear_o = (state_q == ST_CLEAR);
    assign cnt_en_o    = (state_q == ST_GATE);
    assign res_valid_o = (state_q == ST_REPORT);
    assign res_data_o  = res_data_q;
    assign res_src_o   = res_src_q;
    assign res_sat_o   = res_sat_q;

endmodule

// File: tb/tb_ro_meas_scheduler.sv
// Directed bench for ro_meas_scheduler with default parameters (settle 64, hold 2).
module tb_ro_meas_scheduler;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic [1:0]  osc_en;
    logic        osc_sel;
    logic        cnt_clear;
    logic        cnt_en;
    logic [15:0] cnt_value;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_src;
    logic        res_sat;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int gateRun = 0, lastGate = 0, gateSum = 0, gateCount = 0;
    int clearCnt = 0, bothCnt = 0, invCycles = 0, nandCycles = 0, preValid = 0;
    int xferCnt = 0, srcOnes = 0;
    logic [15:0] lastData = '0;
    logic        lastSrc = 1'b0;
    logic        lastSat = 1'b0;
    logic        srcLog[$];

    int xBase, gBase, cBase, iBase, nBase, pBase, sBase, sumBase;

    ro_meas_scheduler dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .cmd_valid_i (cmd_valid),
        .cmd_data_i  (cmd_data),
        .osc_en_o    (osc_en),
        .osc_sel_o   (osc_sel),
        .cnt_clear_o (cnt_clear),
        .cnt_en_o    (cnt_en),
        .cnt_value_i (cnt_value),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .res_src_o   (res_src),
        .res_sat_o   (res_sat),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle-level observation of the DUT, sampled on the falling edge.
    always @(negedge clk) begin
        if (cnt_en) begin
            gateRun++;
        end else if (gateRun != 0) begin
            lastGate = gateRun;
            gateSum += gateRun;
            gateCount++;
            gateRun = 0;
        end
        if (cnt_clear) clearCnt++;
        if (osc_en == 2'b11) bothCnt++;
        if (osc_en == 2'b01) invCycles++;
        if (osc_en == 2'b10) nandCycles++;
        if (busy && !res_valid) preValid++;
        if (res_valid && res_ready) begin
            xferCnt++;
            lastData = res_data;
            lastSrc  = res_src;
            lastSat  = res_sat;
            if (res_src) srcOnes++;
            srcLog.push_back(res_src);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, busy, 0);
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, res_valid, 1);
    endtask

    task automatic waitGate(input string tag, input int doneGates, input int budget);
        int n = 0;
        while (!(cnt_en && gateCount == doneGates) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, cnt_en, 1);
    endtask

    task automatic snapshot();
        xBase   = xferCnt;
        gBase   = gateCount;
        cBase   = clearCnt;
        iBase   = invCycles;
        nBase   = nandCycles;
        pBase   = preValid;
        sBase   = srcOnes;
        sumBase = gateSum;
    endtask

    task automatic checkAllIdle(input string tag);
        checkOutput({tag, "_osc_en"}, osc_en, 0);
        checkOutput({tag, "_osc_sel"}, osc_sel, 0);
        checkOutput({tag, "_cnt_clear"}, cnt_clear, 0);
        checkOutput({tag, "_cnt_en"}, cnt_en, 0);
        checkOutput({tag, "_res_valid"}, res_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cnt_value = 16'h1234;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllIdle("rst");
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_src", res_src, 0);
        checkOutput("rst_res_sat", res_sat, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single INV measurement");
        snapshot();
        applyStimulus(8'h01);
        checkOutput("t1_busy_after_cmd", busy, 1);
        checkOutput("t1_osc_en_after_cmd", osc_en, 1);
        waitIdle("t1_wait_idle", 3000);
        checkOutput("t1_xfers", xferCnt - xBase, 1);
        checkOutput("t1_data", lastData, 16'h1234);
        checkOutput("t1_src", lastSrc, 0);
        checkOutput("t1_sat", lastSat, 0);
        checkOutput("t1_clear_pulses", clearCnt - cBase, 1);
        checkOutput("t1_gate_count", gateCount - gBase, 1);
        checkOutput("t1_gate_width", lastGate, 1024);
        checkOutput("t1_latency", preValid - pBase, 64 + 1 + 1024 + 2);
        checkOutput("t1_inv_cycles", invCycles - iBase, 64 + 1 + 1024 + 2 + 1);
        checkOutput("t1_nand_cycles", nandCycles - nBase, 0);

        $display("[TB] ALT pair");
        snapshot();
        applyStimulus(8'h12);
        applyStimulus(8'h01);
        waitIdle("t2_wait_idle", 6000);
        checkOutput("t2_xfers", xferCnt - xBase, 2);
        checkOutput("t2_first_src", srcLog[xBase], 0);
        checkOutput("t2_second_src", srcLog[xBase + 1], 1);
        checkOutput("t2_both_bits", bothCnt, 0);
        checkOutput("t2_inv_cycles", invCycles - iBase, 1092);
        checkOutput("t2_nand_cycles", nandCycles - nBase, 1092);

        $display("[TB] continuous NAND with STOP in third gate");
        snapshot();
        applyStimulus(8'h20);
        applyStimulus(8'h11);
        applyStimulus(8'h02);
        waitGate("t3_wait_third_gate", gBase + 2, 3000);
        applyStimulus(8'h03);
        waitIdle("t3_wait_idle", 3000);
        checkOutput("t3_xfers", xferCnt - xBase, 3);
        checkOutput("t3_src_nand", srcOnes - sBase, 3);
        checkOutput("t3_gate_sum", gateSum - sumBase, 768);
        checkOutput("t3_gate_width", lastGate, 256);
        checkOutput("t3_inv_cycles", invCycles - iBase, 0);

        $display("[TB] back-pressure in REPORT");
        snapshot();
        res_ready = 1'b0;
        applyStimulus(8'h01);
        waitValid("t4_wait_valid", 2000);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            checkOutput("t4_valid_stable", res_valid, 1);
            checkOutput("t4_data_stable", res_data, 16'h1234);
        end
        checkOutput("t4_src", res_src, 1);
        checkOutput("t4_no_xfer_yet", xferCnt - xBase, 0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        waitIdle("t4_wait_idle", 100);
        checkOutput("t4_xfers", xferCnt - xBase, 1);

        $display("[TB] saturation, ignored START, exponent change mid-gate");
        snapshot();
        cnt_value = 16'hFFFF;
        applyStimulus(8'h10);
        applyStimulus(8'h22);
        applyStimulus(8'h01);
        waitGate("t5_wait_gate", gBase, 200);
        applyStimulus(8'h01);
        applyStimulus(8'h25);
        waitValid("t5_wait_valid", 3000);
        checkOutput("t5_sat", res_sat, 1);
        checkOutput("t5_data", res_data, 16'hFFFF);
        waitIdle("t5_wait_idle", 100);
        checkOutput("t5_xfers", xferCnt - xBase, 1);
        checkOutput("t5_gate_width", lastGate, 1024);
        applyStimulus(8'h01);
        waitIdle("t5_wait_idle_long", 12000);
        checkOutput("t5_next_gate", lastGate, 8192);
        checkOutput("t5_xfers_total", xferCnt - xBase, 2);
        checkOutput("t5_src", lastSrc, 0);

        $display("[TB] reset during GATE");
        cnt_value = 16'h1234;
        applyStimulus(8'h11);
        applyStimulus(8'h20);
        applyStimulus(8'h01);
        snapshot();
        waitGate("t6_wait_gate", gBase, 200);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllIdle("t6_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t6_no_result", xferCnt - xBase, 0);
        applyStimulus(8'h01);
        checkOutput("t6_osc_en_inv", osc_en, 1);
        waitIdle("t6_wait_idle", 3000);
        checkOutput("t6_xfers", xferCnt - xBase, 1);
        checkOutput("t6_src", lastSrc, 0);
        checkOutput("t6_gate_width", lastGate, 1024);
        checkOutput("t6_data", lastData, 16'h1234);
        checkOutput("final_both_bits", bothCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
